// File: rtl/procesador_fifo_pkg.sv
// Shared constants for the memory-mapped to streaming coefficient FIFO:
// register addresses, STATUS/CONTROL bit positions and a STATUS packer.
package procesador_fifo_pkg;

   // Register map of the single Avalon-MM slave port
   localparam logic [1:0] ADDR_DATA    = 2'd0;  // write pushes one word
   localparam logic [1:0] ADDR_STATUS  = 2'd1;  // read only
   localparam logic [1:0] ADDR_CONTROL = 2'd2;  // write only
   localparam logic [1:0] ADDR_RSVD    = 2'd3;  // writes ignored, reads 0

   // STATUS layout
   localparam int STAT_LEVEL_W   = 14;
   localparam int STAT_EMPTY_BIT = 16;
   localparam int STAT_FULL_BIT  = 17;
   localparam int STAT_OVF_BIT   = 18;

   // CONTROL layout
   localparam int CTRL_FLUSH_BIT   = 0;
   localparam int CTRL_CLR_OVF_BIT = 1;

   // Assemble the STATUS word; unused bits read as zero.
   function automatic logic [31:0] pack_status(input logic [STAT_LEVEL_W-1:0] level,
                                               input logic empty,
                                               input logic full,
                                               input logic ovf);
      logic [31:0] s;
      s                     = '0;
      s[STAT_LEVEL_W-1:0]   = level;
      s[STAT_EMPTY_BIT]     = empty;
      s[STAT_FULL_BIT]      = full;
      s[STAT_OVF_BIT]       = ovf;
      return s;
   endfunction

endpackage

// File: rtl/procesador_fifo_ram.sv
// Simple dual-port storage: one write port, one read port with a registered
// read. No reset on the array or the read register; the owner gates the output.
module procesador_fifo_ram #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Write port plus registered read; the read register holds when re_i is low
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/procesador_fifo_coef_mm_to_st.sv
// Memory-mapped to streaming FIFO. Words written to DATA are buffered in a
// synchronous RAM and presented first-word-fall-through on an Avalon-ST source.
//
// Stream handshake: a word moves only on a clock edge where source_valid and
// source_ready are both 1. Once valid rises it stays up, with data stable,
// until that transfer happens (ready latency 0, ready may toggle freely).
//
// The RAM read register doubles as the output register: a RAM read is issued
// whenever the output slot is free or being drained this cycle and the RAM
// still holds unread words. valid_q marks that the read register holds the
// head word; source_data is forced to zero while valid is low.
module procesador_fifo_coef_mm_to_st
   import procesador_fifo_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 32
) (
   input  logic             wrclock,
   input  logic             reset_n,
   input  logic [1:0]       avalonmm_write_slave_address,
   input  logic             avalonmm_write_slave_write,
   input  logic [31:0]      avalonmm_write_slave_writedata,
   input  logic             avalonmm_write_slave_read,
   output logic [31:0]      avalonmm_write_slave_readdata,
   output logic [WIDTH-1:0] avalonst_source_data,
   output logic             avalonst_source_valid,
   input  logic             avalonst_source_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;   // level spans 0..DEPTH inclusive

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             valid_q, valid_d;
   logic             ovf_q, ovf_d;
   logic [31:0]      rdata_q, rdata_d;

   logic             full, empty;
   logic             wr_data, wr_ctrl, wr_acc;
   logic             flush, clr_ovf;
   logic             xfer, rd_en;
   logic [LW-1:0]    ram_cnt;
   logic [31:0]      status_word;
   logic [WIDTH-1:0] ram_rdata;

   // Decode, handshake and occupancy terms, all from registered state
   always_comb begin
      full        = (level_q == LW'(DEPTH));
      empty       = (level_q == '0);
      wr_data     = avalonmm_write_slave_write && (avalonmm_write_slave_address == ADDR_DATA);
      wr_ctrl     = avalonmm_write_slave_write && (avalonmm_write_slave_address == ADDR_CONTROL);
      wr_acc      = wr_data && !full;
      flush       = wr_ctrl && avalonmm_write_slave_writedata[CTRL_FLUSH_BIT];
      clr_ovf     = wr_ctrl && avalonmm_write_slave_writedata[CTRL_CLR_OVF_BIT];
      xfer        = valid_q && avalonst_source_ready;
      // Words still sitting in the RAM, excluding the one in the output register
      ram_cnt     = level_q - LW'(valid_q);
      rd_en       = (ram_cnt != '0) && (!valid_q || avalonst_source_ready);
      status_word = pack_status(STAT_LEVEL_W'(level_q), empty, full, ovf_q);
   end

   // Next state for pointers, level, output valid, overflow and read data
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      rdata_d  = rdata_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         valid_d  = 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         level_d = level_q + LW'(wr_acc) - LW'(xfer);
         if (rd_en) begin
            valid_d = 1'b1;
         end else if (xfer) begin
            valid_d = 1'b0;
         end
      end

      // Setting overflow takes priority over clearing it
      if (wr_data && full) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end

      if (avalonmm_write_slave_read) begin
         case (avalonmm_write_slave_address)
            ADDR_STATUS: rdata_d = status_word;
            ADDR_DATA,
            ADDR_CONTROL,
            ADDR_RSVD:   rdata_d = '0;
            default:     rdata_d = '0;
         endcase
      end
   end

   // Control state register
   always_ff @(posedge wrclock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         rdata_q  <= rdata_d;
      end
   end

   procesador_fifo_ram #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (wrclock),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (avalonmm_write_slave_writedata),
      .re_i    (rd_en),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   assign avalonst_source_valid         = valid_q;
   assign avalonst_source_data          = valid_q ? ram_rdata : '0;
   assign avalonmm_write_slave_readdata = rdata_q;

endmodule

// File: tb/tb_procesador_fifo_coef_mm_to_st.sv
// Directed bench for the MM-to-ST FIFO. Inputs change and outputs are sampled
// on the falling edge; the DUT acts on the rising edge.
module tb_procesador_fifo_coef_mm_to_st;

   localparam int DEPTH   = 32;
   localparam int N_WRAP  = 3 * DEPTH + 7;

   // clock / reset
   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   logic [1:0]  addr;
   logic        wr;
   logic        rd;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] sdata;
   logic        svalid;
   logic        sready;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] exp_q[$];
   logic [31:0] r;
   int          sent, got, lvl_m;

   procesador_fifo_coef_mm_to_st #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) dut (
      .wrclock                         (clk),
      .reset_n                         (rst_n),
      .avalonmm_write_slave_address    (addr),
      .avalonmm_write_slave_write      (wr),
      .avalonmm_write_slave_writedata  (wdata),
      .avalonmm_write_slave_read       (rd),
      .avalonmm_write_slave_readdata   (rdata),
      .avalonst_source_data            (sdata),
      .avalonst_source_valid           (svalid),
      .avalonst_source_ready           (sready)
   );

   task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
      n_vec++;
      if (got_v !== exp_v) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
      end
   endtask

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic mm_write(input logic [1:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wr    = 1'b1;
      @(negedge clk);
      wr    = 1'b0;
   endtask

   task automatic mm_read(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      rd   = 1'b1;
      @(negedge clk);
      rd   = 1'b0;
      d    = rdata;
   endtask

   initial begin
      rst_n  = 1'b0;
      addr   = '0;
      wr     = 1'b0;
      rd     = 1'b0;
      wdata  = '0;
      sready = 1'b0;
      tick(2);
      chk("rst_valid", 32'(svalid), 32'd0);
      chk("rst_data", sdata, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      rst_n = 1'b1;
      tick(1);
      mm_read(2'd1, r);
      chk("rst_status", r, 32'h0001_0000);

      // latency: write at N, valid at N+2 only
      sready = 1'b1;
      mm_write(2'd0, 32'hA5A5_0001);
      chk("lat_n1_valid", 32'(svalid), 32'd0);
      tick(1);
      chk("lat_n2_valid", 32'(svalid), 32'd1);
      chk("lat_n2_data", sdata, 32'hA5A5_0001);
      tick(1);
      chk("lat_after_valid", 32'(svalid), 32'd0);
      mm_read(2'd1, r);
      chk("lat_status", r, 32'h0001_0000);

      // backpressure: hold first word, then drain without bubbles
      sready = 1'b0;
      for (int i = 1; i <= 5; i++) mm_write(2'd0, 32'(i));
      chk("bp_valid", 32'(svalid), 32'd1);
      chk("bp_data", sdata, 32'd1);
      mm_read(2'd1, r);
      chk("bp_status", r, 32'h0000_0005);
      chk("bp_hold_data", sdata, 32'd1);
      sready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         chk("bp_drain_valid", 32'(svalid), 32'd1);
         chk("bp_drain_data", sdata, 32'(i));
         tick(1);
      end
      chk("bp_end_valid", 32'(svalid), 32'd0);
      sready = 1'b0;

      // full and overflow
      for (int i = 0; i < DEPTH + 3; i++) mm_write(2'd0, 32'(i));
      mm_read(2'd1, r);
      chk("full_status", r, 32'h0006_0000 | 32'(DEPTH));
      sready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("full_drain_valid", 32'(svalid), 32'd1);
         chk("full_drain_data", sdata, 32'(i));
         tick(1);
      end
      sready = 1'b0;
      chk("full_end_valid", 32'(svalid), 32'd0);
      mm_read(2'd1, r);
      chk("ovf_sticky_status", r, 32'h0005_0000);
      mm_write(2'd2, 32'h2);
      mm_read(2'd1, r);
      chk("ovf_clear_status", r, 32'h0001_0000);
      tick(3);
      chk("rdata_hold", rdata, 32'h0001_0000);

      // wrap-around with random ready, scoreboard checks order
      sent  = 0;
      got   = 0;
      lvl_m = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 4000 && got < N_WRAP; cyc++) begin
         sready = 1'($urandom_range(0, 1));
         if (sent < N_WRAP && lvl_m < DEPTH && $urandom_range(0, 1) == 1) begin
            addr  = 2'd0;
            wdata = 32'h1000 + 32'(sent);
            wr    = 1'b1;
            exp_q.push_back(wdata);
            sent++;
            lvl_m++;
         end else begin
            wr = 1'b0;
         end
         if (svalid && sready) begin
            chk("wrap_data", sdata, (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
            got++;
            lvl_m--;
         end
         @(negedge clk);
      end
      wr     = 1'b0;
      sready = 1'b0;
      chk("wrap_count", 32'(got), 32'(N_WRAP));
      chk("wrap_end_valid", 32'(svalid), 32'd0);
      mm_read(2'd1, r);
      chk("wrap_status", r, 32'h0001_0000);

      // reserved address, then flush
      for (int i = 0; i < 10; i++) mm_write(2'd0, 32'h100 + 32'(i));
      mm_write(2'd3, 32'hFFFF_FFFF);
      mm_read(2'd1, r);
      chk("rsvd_wr_status", r, 32'h0000_000A);
      mm_read(2'd3, r);
      chk("rsvd_rd", r, 32'd0);
      chk("fl_pre_valid", 32'(svalid), 32'd1);
      chk("fl_pre_data", sdata, 32'h100);
      mm_write(2'd2, 32'h1);
      chk("fl_valid", 32'(svalid), 32'd0);
      mm_read(2'd1, r);
      chk("fl_status", r, 32'h0001_0000);
      mm_write(2'd0, 32'h55);
      chk("fl_new_n1_valid", 32'(svalid), 32'd0);
      tick(1);
      chk("fl_new_n2_valid", 32'(svalid), 32'd1);
      chk("fl_new_n2_data", sdata, 32'h55);
      sready = 1'b1;
      tick(1);
      sready = 1'b0;

      // reset mid-operation
      for (int i = 0; i < 20; i++) mm_write(2'd0, 32'h200 + 32'(i));
      mm_read(2'd1, r);
      chk("mid_status", r, 32'h0000_0014);
      chk("mid_valid", 32'(svalid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(svalid), 32'd0);
      chk("mid_rst_data", sdata, 32'd0);
      chk("mid_rst_rdata", rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);
      mm_read(2'd1, r);
      chk("mid_post_status", r, 32'h0001_0000);
      mm_write(2'd0, 32'h77);
      chk("mid_new_n1_valid", 32'(svalid), 32'd0);
      tick(1);
      chk("mid_new_n2_valid", 32'(svalid), 32'd1);
      chk("mid_new_n2_data", sdata, 32'h77);

      // report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
